// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B - BIN (mod 2^WIDTH), with
// borrow-out in BOUT. Operands are taken on a start/busy/done handshake and
// processed one bit per clock, LSB first. Results stay registered until the
// next operation completes or until reset.
module serial_subtractor #(
  parameter int WIDTH = 4,  // operand/result width, legal 2..16
  parameter int CW    = 5   // bit counter width, 2^CW must exceed WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;      // minuend, shifted right one bit per SHIFT edge
  logic [WIDTH-1:0] b_sr;      // subtrahend, shifted alongside a_sr
  logic [WIDTH-1:0] res_sr;    // difference bits enter at the MSB
  logic             br;        // running borrow between bit positions
  logic [CW-1:0]    cnt;       // index of the bit being processed

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;

  // One full-subtractor cell applied to the current bit position.
  always_comb begin
    a_bit    = a_sr[0];
    b_bit    = b_sr[0];
    d_bit    = a_bit ^ b_bit ^ br;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; busy/done are decoded from the next state so that they
  // come straight out of flops with no logic behind them.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Operand capture, per-bit shifting and final result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      DIFF   <= '0;
      BOUT   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            br     <= BIN;
            res_sr <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            DIFF <= {d_bit, res_sr[WIDTH-1:1]};
            BOUT <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed handshake scenarios, an exhaustive
// sweep of all 4-bit operand/borrow combinations and randomized operations,
// with a per-cycle comparison against a countdown-based reference model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 0;

  serial_subtractor #(.WIDTH(W), .CW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (op_a),
    .B     (op_b),
    .BIN   (op_bin),
    .DIFF  (diff),
    .BOUT  (bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation occupies W+1 cycles; the result,
  // computed arithmetically at accept time, becomes visible W edges later.
  int           m_left = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic [W-1:0] p_diff = '0;
  logic         p_bout = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_diff = '0;
      m_bout = 1'b0;
    end else if (m_left == 0) begin
      if (start === 1'b1) begin
        m_left = W + 1;
        p_diff = W'((int'(op_a) + (1 << W) - int'(op_b) - int'(op_bin)) % (1 << W));
        p_bout = (int'(op_a) < int'(op_b) + int'(op_bin));
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_diff = p_diff;
        m_bout = p_bout;
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left != 0));
      check("done", 32'(done), 32'(m_left == 1));
      check("diff", 32'(diff), 32'(m_diff));
      check("bout", 32'(bout), 32'(m_bout));
    end
  end

  // Starts one operation from an idle negedge, waits for done (bounded) and
  // returns the number of cycles from the start edge to the done cycle.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, output int lat);
    op_a   = a;
    op_b   = b;
    op_bin = bi;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  // Leaves the DONE cycle so the block is idle at the returned negedge.
  task automatic to_idle();
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [4:0] exp5;

    rst    = 1'b1;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    op_bin = 1'b0;
    @(negedge clk);
    chk_en = 1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First op with latency measurement.
    launch(4'b0011, 4'b1100, 1'b0, lat);
    check("latency", 32'(lat), 32'(W + 1));
    check("op1_diff", 32'(diff), 32'b0111);
    check("op1_bout", 32'(bout), 32'd1);
    to_idle();

    // Back-to-back operations.
    launch(4'b1111, 4'b1101, 1'b1, lat);
    check("b2b1_diff", 32'({bout, diff}), 32'b0_0001);
    to_idle();
    launch(4'b1101, 4'b1001, 1'b1, lat);
    check("b2b2_diff", 32'({bout, diff}), 32'b0_0011);
    to_idle();
    launch(4'b1001, 4'b1111, 1'b1, lat);
    check("b2b3_diff", 32'({bout, diff}), 32'b1_1001);
    to_idle();

    // start held high with operands toggling throughout the operation.
    op_a   = 4'b0000;
    op_b   = 4'b0000;
    op_bin = 1'b1;
    start  = 1'b1;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
      op_a   = W'($urandom);
      op_b   = W'($urandom);
      op_bin = 1'($urandom);
    end while (done !== 1'b1 && lat < 30);
    check("hold_lat", 32'(lat), 32'(W + 1));
    check("hold_diff", 32'({bout, diff}), 32'b1_1111);
    op_a   = 4'b0101;
    op_b   = 4'b0011;
    op_bin = 1'b0;
    @(negedge clk);
    check("hold_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("hold_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("reaccept_diff", 32'({bout, diff}), 32'b0_0010);
    to_idle();

    // Reset aborts an operation at the second SHIFT edge.
    op_a   = 4'b1010;
    op_b   = 4'b0101;
    op_bin = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'({bout, diff}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    launch(4'b0110, 4'b0010, 1'b0, lat);
    check("post_abort", 32'({bout, diff}), 32'b0_0100);
    to_idle();

    // Idle hold: results stay put, no activity.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_diff", 32'({bout, diff}), 32'b0_0100);
      check("idle_busy", 32'({busy, done}), 32'd0);
    end

    // Exhaustive sweep of all (A, B, BIN) combinations.
    for (int i = 0; i < 512; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      a  = W'(i >> 5);
      b  = W'(i >> 1);
      bi = 1'(i);
      launch(a, b, bi, lat);
      exp5 = 5'(int'(a) - int'(b) - int'(bi));
      check("exh_sub", 32'({bout, diff}), 32'(exp5));
      check("exh_add", 32'(W'(diff + b + W'(bi))), 32'(a));
      to_idle();
    end

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(W'($urandom), W'($urandom), 1'($urandom), lat);
      check("rnd_lat", 32'(lat), 32'(W + 1));
      to_idle();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor with borrow-in. It computes A − B − BIN one bit per clock, LSB first.
- It is the inverse-direction companion to the team's 4-bit ripple Adder: DIFF + B + BIN ≡ A (mod 2^WIDTH).
- Operands are accepted through a start/busy/done handshake. Registered results are held until the next operation.
- It sits beside the Adder in the arithmetic datapath, where a compact multi-cycle subtract is acceptable.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.
- CW, 5, width of the internal bit counter; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- BIN  input  1  borrow-in; captured on the accepting edge.
- DIFF  output  WIDTH  registered difference, A − B − BIN mod 2^WIDTH.
- BOUT  output  1  registered borrow-out; 1 when A < B + BIN (unsigned).
- busy  output  1  high while an operation is in progress (SHIFT and DONE).
- done  output  1  one-cycle pulse; DIFF/BOUT are newly valid while it is high.

Interface (already decided):
- One clock; reset is synchronous and active-high.
- Ports are named clk and rst.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - DIFF=0, BOUT=0, busy=0, done=0.
  - Internal shift registers, borrow flop and counter are cleared.
  - rst has priority over all other inputs and aborts any operation in flight. DIFF/BOUT do not update from the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: capture A, B and BIN into the internal registers, clear cnt, go to SHIFT.
  - With start=0: remain in IDLE. DIFF/BOUT hold their previous values.
- SHIFT (busy=1, done=0). Each edge processes one bit:
  - Inputs: a = LSB of the A shift register, b = LSB of the B shift register, br = borrow flop.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - d is shifted into the MSB of the result shift register. The A and B registers shift right, and cnt increments.
  - On the edge that processes bit WIDTH−1:
    - DIFF is loaded from the completed result.
    - BOUT is loaded from br_next.
    - State goes to DONE.
- DONE (busy=1, done=1 for exactly one cycle): the next edge goes unconditionally to IDLE.
- Latency:
  - The accept edge is edge 0. DIFF/BOUT update at edge WIDTH, and done is high in the cycle after edge WIDTH.
  - For WIDTH=4, done is high in the 5th cycle after the start edge.
  - The earliest next accept is edge WIDTH+1, so throughput is one operation per WIDTH+1 cycles.
- start is ignored whenever state ≠ IDLE, including the DONE cycle. Operand changes on A/B/BIN after the accept edge have no effect.
- DIFF/BOUT change only at the final SHIFT edge or at reset, and are stable otherwise.
- Arithmetic is unsigned modulo 2^WIDTH, with no overflow flag.
- Boundary values:
  - A=B, BIN=0 → DIFF=0, BOUT=0.
  - A=0, B=0, BIN=1 → DIFF=all ones, BOUT=1.
  - A=all ones, B=all ones, BIN=1 → DIFF=all ones, BOUT=1.
- No combinational path exists from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then A=0011, B=1100, BIN=0, start for 1 cycle → done pulses 5 cycles later; DIFF=0111, BOUT=1; busy high for 5 cycles.
- Back-to-back ops, each started on the cycle after done:
  - 1111−1101, BIN=1 → DIFF=0001, BOUT=0.
  - 1101−1001, BIN=1 → DIFF=0011, BOUT=0.
  - 1001−1111, BIN=1 → DIFF=1001, BOUT=1.
- Start 0000−0000, BIN=1; hold start=1 and toggle A/B throughout the operation → exactly one op; DIFF=1111, BOUT=1; start during DONE is ignored; a new op is accepted on the first IDLE edge.
- Start 1010−0101, BIN=0; assert rst at the 2nd SHIFT edge → next cycle busy=0, done=0, DIFF=0, BOUT=0; no done pulse follows. A new op (0110−0010, BIN=0) then gives DIFF=0100, BOUT=0.
- Exhaustive, WIDTH=4, all 512 (A, B, BIN) combinations → for each: {BOUT,DIFF} = (A − B − BIN) mod 32 as a 5-bit value. Cross-check DIFF + B + BIN (mod 16) = A, computed with an Adder instance.
- After done, hold start=0 for 20 cycles → DIFF/BOUT stable, done stays 0, busy stays 0.
